// File: rtl/core_mem_arbiter_pkg.sv
// Shared types and bus-ID helpers for the per-core memory arbiter.
package core_mem_arbiter_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    read_req  = 2'd0,
    write_req = 2'd1,
    read_rsp  = 2'd2,
    write_ack = 2'd3
  } bus_packet_type_t;

  typedef enum logic [7:0] {
    FETCH = 8'd0,
    LOAD  = 8'd1,
    STORE = 8'd2
  } component_type_t;

  // Bus ID layout is {core[7:0], component[7:0]}.
  function automatic logic [15:0] createBusID(input logic [7:0] core_id, input logic [7:0] component);
    return {core_id, component};
  endfunction

  function automatic logic [7:0] bus_id_core(input logic [15:0] id);
    return id[15:8];
  endfunction

  function automatic logic [7:0] bus_id_component(input logic [15:0] id);
    return id[7:0];
  endfunction

endpackage

// File: rtl/core_mem_arbiter_rr_pick.sv
// Combinational round-robin pick: first candidate at or after ptr, wrapping modulo N.
module rr_pick
  import core_mem_arbiter_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     candidates,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  // Scan from the farthest offset down so the nearest candidate to ptr wins last.
  always_comb begin
    logic [IDX_W:0] pos;
    grant     = '0;
    grant_idx = '0;
    pos       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (pos >= (IDX_W + 1)'(N)) pos = pos - (IDX_W + 1)'(N);
      if (candidates[pos[IDX_W-1:0]]) begin
        grant                   = '0;
        grant[pos[IDX_W-1:0]]   = 1'b1;
        grant_idx               = pos[IDX_W-1:0];
      end
    end
  end

  assign any = |candidates;

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one core memory bus port among fetch/load/store requesters and routes
// responses back by the component field of the bus ID.
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
#(
  parameter logic [7:0] CORE_ID = 8'd0,
  parameter int         N_REQ   = 3,
  parameter int         ADDR_W  = core_mem_arbiter_pkg::ADDR_W,
  parameter int         DATA_W  = core_mem_arbiter_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ-1:0]         req_is_write,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [1:0]               mem_req_type,
  output logic [ADDR_W-1:0]        mem_req_addr,
  output logic [DATA_W-1:0]        mem_req_data,
  output logic [15:0]              mem_req_id,
  input  logic                     mem_rsp_valid,
  output logic                     mem_rsp_ready,
  input  logic [1:0]               mem_rsp_type,
  input  logic [15:0]              mem_rsp_id,
  input  logic [DATA_W-1:0]        mem_rsp_data,
  output logic [N_REQ-1:0]         rsp_valid,
  input  logic [N_REQ-1:0]         rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     bad_rsp
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  issue_idx;
  logic [IDX_W-1:0]  grant_idx;
  logic [N_REQ-1:0]  outstanding;
  logic [N_REQ-1:0]  candidates;
  logic [N_REQ-1:0]  grant;
  logic              grant_any;
  logic [N_REQ-1:0]  slot_full;
  logic [DATA_W-1:0] slot_data [N_REQ];
  logic [1:0]        slot_type [N_REQ];

  logic [7:0] rsp_comp;
  logic       rsp_out;
  logic       rsp_full;
  logic       rsp_good;
  logic       rsp_accept;

  assign candidates = req_valid & ~outstanding;

  rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
    .candidates (candidates),
    .ptr        (rr_ptr),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any        (grant_any)
  );

  // Handshake outputs are gated by reset so every output reads 0 while reset is held.
  assign req_ready = (reset_n && state == ST_IDLE) ? grant : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      issue_idx     <= '0;
      mem_req_valid <= 1'b0;
      mem_req_type  <= '0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
      mem_req_id    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            state         <= ST_ISSUE;
            issue_idx     <= grant_idx;
            mem_req_valid <= 1'b1;
            mem_req_type  <= req_is_write[grant_idx] ? 2'(write_req) : 2'(read_req);
            mem_req_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
            mem_req_data  <= req_wdata[grant_idx*DATA_W +: DATA_W];
            mem_req_id    <= createBusID(CORE_ID, 8'(grant_idx));
          end
        end
        default: begin
          if (mem_req_ready) begin
            state         <= ST_IDLE;
            mem_req_valid <= 1'b0;
            rr_ptr        <= (issue_idx == IDX_W'(N_REQ - 1)) ? '0 : issue_idx + 1'b1;
          end
        end
      endcase
    end
  end

  assign rsp_comp = bus_id_component(mem_rsp_id);

  always_comb begin
    rsp_out  = 1'b0;
    rsp_full = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rsp_comp == 8'(i)) begin
        rsp_out  = outstanding[i];
        rsp_full = slot_full[i];
      end
    end
  end

  // Out-of-range components never match above, so they fall out as invalid.
  assign rsp_good      = (bus_id_core(mem_rsp_id) == CORE_ID) && rsp_out;
  assign mem_rsp_ready = reset_n && (!rsp_good || !rsp_full);
  assign rsp_accept    = mem_rsp_valid && mem_rsp_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
      slot_full   <= '0;
      bad_rsp     <= 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        slot_data[i] <= '0;
        slot_type[i] <= '0;
      end
    end else begin
      bad_rsp <= rsp_accept && !rsp_good;
      for (int i = 0; i < N_REQ; i++) begin
        if (slot_full[i] && rsp_ready[i]) slot_full[i] <= 1'b0;
        if (state == ST_ISSUE && mem_req_ready && issue_idx == IDX_W'(i)) outstanding[i] <= 1'b1;
        if (rsp_accept && rsp_good && rsp_comp == 8'(i)) begin
          outstanding[i] <= 1'b0;
          slot_full[i]   <= 1'b1;
          slot_data[i]   <= mem_rsp_data;
          slot_type[i]   <= mem_rsp_type;
        end
      end
    end
  end

  assign rsp_valid = slot_full;

  // Write acks carry no payload; the shared bus shows the lowest full slot.
  always_comb begin
    rsp_data = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (slot_full[i]) rsp_data = (slot_type[i] == 2'(write_ack)) ? '0 : slot_data[i];
    end
  end

  assert property (@(posedge clk) disable iff (!reset_n)
    $past(mem_req_valid && !mem_req_ready) |->
      (mem_req_valid && $stable(mem_req_type) && $stable(mem_req_addr) &&
       $stable(mem_req_data) && $stable(mem_req_id)));

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares one core-level memory bus port among three per-core requesters: fetch (0), load (1), store (2).
- Arbitrates requests round-robin, allows at most one outstanding transaction per requester, and routes each response back by the component field of its bus ID.
- Sits between the pipeline stages' memory interfaces and the core's cache/memory bus.

Parameters:
- CORE_ID, 0, 8-bit core identifier; a response whose core field differs is dropped and flagged.
- N_REQ, 3, number of requesters; index equals component type (FETCH=0, LOAD=1, STORE=2).
- ADDR_W, 64, address width.
- DATA_W, 64, payload width.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester request accepted this cycle
- req_is_write  in  N_REQ  1 = write request, 0 = read request
- req_addr  in  N_REQ*ADDR_W  request addresses
- req_wdata  in  N_REQ*DATA_W  write payloads
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream accepts request
- mem_req_type  out  2  packet type: 0 read_req, 1 write_req
- mem_req_addr  out  ADDR_W  downstream address
- mem_req_data  out  DATA_W  downstream payload
- mem_req_id  out  16  bus ID {CORE_ID[7:0], component[7:0]}
- mem_rsp_valid  in  1  downstream response valid
- mem_rsp_ready  out  1  arbiter accepts response
- mem_rsp_type  in  2  packet type: 2 read_rsp, 3 write_ack
- mem_rsp_id  in  16  response bus ID
- mem_rsp_data  in  DATA_W  response payload
- rsp_valid  out  N_REQ  per-requester response valid
- rsp_ready  in  N_REQ  requester consumes response
- rsp_data  out  DATA_W  shared response payload bus
- bad_rsp  out  1  one-cycle pulse on a dropped or misrouted response

Behaviour:
- Reset values: all outputs 0. rr_ptr=0, outstanding=0, all response slots empty.
- Request FSM states:
  - IDLE: candidates are requesters with req_valid=1 and outstanding[i]=0. Pick the first candidate at or after rr_ptr, wrapping modulo N_REQ. Assert req_ready[i] for exactly that cycle and latch type/addr/data/id. Go to ISSUE.
  - ISSUE: hold mem_req_* stable with mem_req_valid=1 until mem_req_ready=1. On that handshake: set outstanding[g]=1, set rr_ptr=(g+1) mod N_REQ, go to IDLE.
- Request latency: IDLE grant cycle, then mem_req_valid the next cycle. Minimum issue rate is one request per 2 cycles.
- Response slot per requester: 1 entry holding data and type.
  - mem_rsp_ready = 1 iff the slot addressed by mem_rsp_id[7:0] is empty, or the id is invalid (so invalid responses are always drained).
  - On accept: fill slot c and clear outstanding[c].
  - rsp_valid[c] = slot c full. Clear the slot when rsp_ready[c]=1.
  - rsp_data is the payload of the lowest-indexed full slot. Requesters only sample it when their own rsp_valid is set; the stage may hold only one slot full at a time.
- Invalid response (core field != CORE_ID, component >= N_REQ, or outstanding[c]=0): accept and drop, pulse bad_rsp, state unchanged.
- Simultaneous events:
  - A response clearing outstanding[i] and a new grant to i in the same cycle: the grant sees the old outstanding value, so i is not granted that cycle.
  - Slot fill and rsp_ready in the same cycle: legal only if the slot was already empty. The new data is presented next cycle.
- Write requests also occupy the outstanding bit until write_ack returns. The ack delivers rsp_valid with rsp_data=0.
- Asynchronous reset mid-transaction discards all state. Downstream must also be reset; late responses after reset are dropped and pulse bad_rsp.
- Invariant (assert): mem_req_* do not change while mem_req_valid=1 and mem_req_ready=0.

Decomposition:
- Shared package holds:
  - bus_packet_type_t enum (read_req=0, write_req=1, read_rsp=2, write_ack=3).
  - component_type_t (FETCH=0, LOAD=1, STORE=2).
  - createBusID and its field-extract functions.
  - ADDR_W and DATA_W constants.
- Sub-module rr_pick: combinational round-robin priority pick, with inputs (candidates, ptr) and outputs (grant onehot, grant index, any).

Test Plan:
- Single fetch read: req_valid[0], addr 0x40 → cycle+1 mem_req_valid with type 0, addr 0x40, id {CORE_ID,0}. A rsp with data 0xDEAD_BEEF_0000_0001 → rsp_valid[0] the next cycle with that data; outstanding cleared.
- All three requesters valid continuously, rr_ptr=0, downstream always ready with instant responses → grant order 0,1,2,0. No requester is granted while outstanding.
- Back-pressure: mem_req_ready low for 5 cycles → mem_req_* stable all 5 cycles; req_ready is not re-asserted for other requesters until the handshake completes.
- Response to a full slot: slot 1 full and rsp_ready[1]=0, response for id 1 arrives → mem_rsp_ready=0 until rsp_ready[1] pulses, then accepted the next cycle.
- Bad ID: response with core field CORE_ID+1, or component 3, or to a non-outstanding requester → mem_rsp_ready=1, bad_rsp pulses once, no rsp_valid.
- Reset mid-ISSUE: assert reset_n=0 while mem_req_valid=1 → all outputs 0 immediately (asynchronously); after release, rr_ptr=0 and the first grant goes to the lowest valid requester.
